// File: rtl/otter_dbg_pkg.sv
// Shared types and widths for the OTTER debug readout logic.
package otter_dbg_pkg;

  localparam int RF_IDX_W  = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/otter_rfile_dump.sv
// Register-file dump engine: borrows the rs1 read port and streams a range
// of register values out over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | o_rf_addr presented, value captured at the edge
// SEND  | word valid, held until handshake
// DONE  | one-cycle o_done pulse
module otter_rfile_dump
  import otter_dbg_pkg::*;
#(
  parameter int START_IDX = 0,
  parameter int END_IDX   = 31
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_rf_req,
  output logic [RF_IDX_W-1:0]  o_rf_addr,
  input  logic [RF_DATA_W-1:0] i_rf_data,
  output logic [RF_DATA_W-1:0] o_data,
  output logic [RF_IDX_W-1:0]  o_idx,
  output logic                 o_last,
  output logic                 o_valid,
  input  logic                 i_ready
);

  if (START_IDX < 0 || START_IDX > END_IDX || END_IDX > 31) begin : g_bad_range
    $error("otter_rfile_dump: need 0 <= START_IDX <= END_IDX <= 31");
  end

  localparam logic [RF_IDX_W-1:0] START_L = RF_IDX_W'(START_IDX);
  localparam logic [RF_IDX_W-1:0] END_L   = RF_IDX_W'(END_IDX);

  dump_state_t          r_state;
  logic [RF_IDX_W-1:0]  r_cnt;
  logic [RF_DATA_W-1:0] r_data;
  logic [RF_IDX_W-1:0]  r_idx;
  logic                 r_last;
  logic                 w_at_end;

  // Counter stops at END_L, so it never has to wrap past 31.
  assign w_at_end = (r_cnt == END_L);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt   <= START_L;
            r_state <= READ;
          end
        end
        READ: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            r_data  <= i_rf_data;
            r_idx   <= r_cnt;
            r_last  <= w_at_end;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else if (i_ready) begin
            if (w_at_end) begin
              r_state <= DONE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= READ;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_done    = (r_state == DONE);
  assign o_rf_req  = (r_state == READ) || (r_state == SEND);
  assign o_valid   = (r_state == SEND);
  assign o_rf_addr = r_cnt;
  assign o_data    = r_data;
  assign o_idx     = r_idx;
  assign o_last    = r_last && (r_state == SEND);

endmodule
